// File: rtl/macc_pkg.sv
// Shared types and constants for the MACC sequencing controller.
package macc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int              OP_W   = 8;
    localparam int              MUL_W  = 15;
    localparam logic signed [15:0] NEG_SQ = 16'sd16384;
    localparam logic [7:0]      OP_MIN = 8'h80;

endpackage

// File: rtl/Mul.sv
// Combinational 8x8 signed radix-4 Booth multiplier with a 15-bit product.
// (-128)*(-128) does not fit in 15 bits and wraps; callers must correct it.
module Mul (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [14:0] p
);

    logic signed [15:0] a_ext;
    logic        [8:0]  b_ext;
    logic        [2:0]  grp;
    logic signed [15:0] pp;
    logic        [15:0] sum;

    assign a_ext = {{8{a[7]}}, a};
    assign b_ext = {b, 1'b0};

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sum = '0;
        grp = '0;
        pp  = '0;
        for (int i = 0; i < 4; i++) begin
            grp = b_ext[2*i+2 -: 3];
            case (grp)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            sum = sum + (16'(pp) << (2*i));
        end
    end

    assign p = sum[14:0];

endmodule

// File: rtl/macc_seq_ctrl.sv
// Dot-product sequencer: accepts operand pairs, pipelines them through Mul,
// accumulates with sticky overflow, and hands back one result per job.
module macc_seq_ctrl
    import macc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_x,
    input  logic [OP_W-1:0]  in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               s1_vld_q, s1_vld_d;
    logic [OP_W-1:0]    s1_x_q, s1_x_d;
    logic [OP_W-1:0]    s1_y_q, s1_y_d;
    logic               s2_vld_q, s2_vld_d;
    logic [ACC_W-1:0]   s2_prod_q, s2_prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [MUL_W-1:0]   mul_p;
    logic [ACC_W-1:0]   sum;
    logic               in_hs;
    logic               out_hs;

    Mul u_mul (
        .a (s1_x_q),
        .b (s1_y_q),
        .p (mul_p)
    );

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;
    assign sum    = acc_q + s2_prod_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        s2_prod_d = s2_prod_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        // The pipeline advances every cycle regardless of FSM state.
        s1_vld_d = in_hs;
        if (in_hs) begin
            s1_x_d = in_x;
            s1_y_d = in_y;
        end
        s2_vld_d = s1_vld_q;
        if (s1_vld_q) begin
            if (s1_x_q == OP_MIN && s1_y_q == OP_MIN)
                s2_prod_d = ACC_W'(NEG_SQ);
            else
                s2_prod_d = {{(ACC_W-MUL_W){mul_p[MUL_W-1]}}, mul_p};
        end
        if (s2_vld_q) begin
            acc_d = sum;
            if (acc_q[ACC_W-1] == s2_prod_q[ACC_W-1] && sum[ACC_W-1] != acc_q[ACC_W-1])
                ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_hs) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_vld_q && !s2_vld_q)
                    state_d = DONE;
            end
            DONE: begin
                if (out_hs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == RUN) && (cnt_d < len_d);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_vld_q    <= 1'b0;
            s2_prod_q   <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_vld_q    <= s2_vld_d;
            s2_prod_q   <= s2_prod_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Directed bench for macc_seq_ctrl: single-product vector table plus
// hand-written multi-cycle sequences with hand-computed expectations.
module tb_macc_seq_ctrl;

    localparam int ACC_W = 24;
    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_x;
    logic [7:0]       in_y;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int y;
        int exp_acc;
    } vec_t;

    vec_t vecs[10];

    macc_seq_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_val();
        return int'($signed(out_acc));
    endfunction

    task automatic start_job(input int len);
        cfg_len = LEN_W'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input int x, input int y);
        int n = 0;
        in_valid = 1'b1;
        in_x     = 8'(x);
        in_y     = 8'(y);
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready)
            check("feed_ready", int'(in_ready), 1);
        else
            tick();
    endtask

    task automatic wait_result(input string name, input int exp_acc, input int exp_ovf);
        int n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_acc"}, acc_val(), exp_acc);
        check({name, "_ovf"}, int'(out_ovf), exp_ovf);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int n_hs;
        int n;

        vecs[0] = '{-128, -128,  16384};
        vecs[1] = '{-128,  127, -16256};
        vecs[2] = '{ 127,  127,  16129};
        vecs[3] = '{   3,    4,     12};
        vecs[4] = '{  -5,    6,    -30};
        vecs[5] = '{   7,   -8,    -56};
        vecs[6] = '{  -1,   -1,      1};
        vecs[7] = '{ 127, -128, -16256};
        vecs[8] = '{  -7,   -9,     63};
        vecs[9] = '{  85,  -86,  -7310};

        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_x = '0; in_y = '0; out_ready = 1'b0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_acc", acc_val(), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        rst = 1'b0;
        tick();

        // Single-product jobs from the vector table.
        for (int i = 0; i < 10; i++) begin
            start_job(1);
            feed(vecs[i].x, vecs[i].y);
            in_valid = 1'b0;
            wait_result($sformatf("vec%0d", i), vecs[i].exp_acc, 0);
            consume($sformatf("vec%0d", i));
        end

        // Basic job, back-to-back pairs, latency check with out_ready high.
        out_ready = 1'b1;
        start_job(3);
        check("basic_in_ready", int'(in_ready), 1);
        feed(3, 4);
        feed(-5, 6);
        feed(7, -8);
        in_valid = 1'b0;
        check("basic_lat1_valid", int'(out_valid), 0);
        check("basic_in_ready_off", int'(in_ready), 0);
        tick();
        check("basic_lat2_valid", int'(out_valid), 0);
        tick();
        check("basic_lat3_valid", int'(out_valid), 0);
        tick();
        check("basic_lat_valid", int'(out_valid), 1);
        check("basic_acc", acc_val(), -74);
        check("basic_ovf", int'(out_ovf), 0);
        tick();
        check("basic_drop", int'(out_valid), 0);
        check("basic_idle", int'(busy), 0);
        check("basic_acc_hold", acc_val(), -74);
        out_ready = 1'b0;

        // Zero length job; start pulses in DONE are ignored.
        start_job(0);
        check("zero_valid", int'(out_valid), 1);
        check("zero_in_ready", int'(in_ready), 0);
        check("zero_acc", acc_val(), 0);
        cfg_len = LEN_W'(5);
        start = 1'b1;
        tick();
        tick();
        check("zero_start_ign_valid", int'(out_valid), 1);
        check("zero_start_ign_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check("zero_hs_valid", int'(out_valid), 0);
        check("zero_hs_busy", int'(busy), 0);
        tick();
        check("zero_hs_stay_idle", int'(busy), 0);

        // Handshake stress with random in_valid gaps and a held result.
        start_job(4);
        n_hs = 0;
        n = 0;
        in_x = 8'd1;
        in_y = 8'd1;
        while (n_hs < 4 && n < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) n_hs++;
            tick();
            n++;
        end
        check("stress_hs_done", n_hs, 4);
        check("stress_ready_off", int'(in_ready), 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_valid && in_ready) n_hs++;
            tick();
        end
        in_valid = 1'b0;
        check("stress_hs_count", n_hs, 4);
        wait_result("stress", 4, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stress_hold_valid%0d", i), int'(out_valid), 1);
            check($sformatf("stress_hold_acc%0d", i), acc_val(), 4);
        end
        consume("stress");

        // Long job that wraps the accumulator.
        start_job(600);
        for (int i = 0; i < 600; i++) feed(-128, -128);
        in_valid = 1'b0;
        wait_result("ovf", -6946816, 1);
        consume("ovf");
        start_job(1);
        feed(2, 3);
        in_valid = 1'b0;
        wait_result("ovf_clear", 6, 0);
        consume("ovf_clear");

        // Reset in the middle of a job.
        start_job(5);
        feed(5, 5);
        feed(6, 6);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        tick();
        tick();
        check("midrst_no_result", int'(out_valid), 0);
        start_job(2);
        feed(10, 10);
        feed(1, 1);
        in_valid = 1'b0;
        wait_result("midrst_new", 101, 0);
        consume("midrst_new");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macc_seq_ctrl.md
Name: macc_seq_ctrl

Overview:
- Sequences the 8x8 signed radix-4 Booth multiplier (`Mul`, 15-bit product) through one dot product per job of the CNN MACC unit.
- Accepts a stream of (activation, weight) pairs over a valid/ready handshake.
- Pipelines each pair through `Mul`, sign-extends and accumulates the products, and returns one result per job over a valid/ready handshake.
- Sits between the line-buffer/weight fetch logic and the post-processing (bias/ReLU) stage.

Parameters:
- ACC_W, 24, accumulator and result width in bits (signed, two's complement; must be >= 16).
- LEN_W, 10, width of the job-length field; a job is at most 2^LEN_W-1 products.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start pulse; honoured only in IDLE.
- cfg_len  in  LEN_W  number of products in the job; sampled when start is honoured.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_x  in  8  signed activation.
- in_y  in  8  signed weight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  signed dot-product result.
- out_ovf  out  1  sticky signed-overflow flag for the job.

Behaviour:
- Reset: at the first rising edge with rst=1, the state goes to IDLE, and:
  - busy=0, in_ready=0, out_valid=0, out_acc=0, out_ovf=0;
  - the pipeline valid bits, accept counter and accumulator are cleared.
- Reset asserted mid-job abandons the job and discards partial sums; no result is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches cfg_len, clears the accumulator, the ovf flag and the counter.
  - It then goes to RUN, or directly to DONE with out_acc=0 when cfg_len=0.
  - start is ignored in all other states.
- RUN:
  - in_ready=1 while count < len.
  - A handshake is in_valid & in_ready at a rising edge; each handshake increments count.
  - When the handshake makes count == len, the FSM goes to DRAIN and in_ready is 0 from the next cycle.
  - in_valid gaps are allowed and stall nothing downstream.
- Pipeline, fixed and non-stallable:
  - S1 registers in_x/in_y plus a valid bit.
  - `Mul` is combinational on the S1 registers.
  - S2 registers the sign-extended product plus a valid bit.
  - S3: the accumulator adds the S2 product when S2 is valid.
- Product correction: `Mul` cannot represent (-128)*(-128). When both S1 operands equal 8'h80, S2 loads +16384 instead of the `Mul` output. All other products are the 15-bit `Mul` output sign-extended to ACC_W.
- Accumulate arithmetic:
  - acc <= acc + prod, modulo 2^ACC_W (wraps).
  - out_ovf is set if any add has operands of equal sign and a sum of the other sign; it stays set until the next start.
- DRAIN: the FSM stays here until S1 and S2 are both empty, then goes to DONE.
  - Latency: out_valid rises at the 3rd rising edge after the final input handshake.
- DONE:
  - out_valid=1; out_acc and out_ovf are held stable while out_valid=1 and out_ready=0.
  - When out_valid & out_ready at an edge, the FSM goes to IDLE with out_valid=0 in the next cycle.
  - start in the same cycle as the result handshake is ignored.
  - out_acc retains its last value in IDLE.
- in_ready is 0 in IDLE, DRAIN and DONE.

Decomposition:
- Shared package macc_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - constant OP_W=8;
  - constant MUL_W=15;
  - constant NEG_SQ=16'sd16384;
  - constant OP_MIN=8'h80.
- One sub-module: the existing `Mul` block, instantiated unchanged.
- The FSM, counter, pipeline registers and accumulator stay in macc_seq_ctrl.

Test Plan:
- Basic job: cfg_len=3, pairs (3,4), (-5,6), (7,-8) sent back to back, out_ready=1 -> out_acc=-74, out_ovf=0, out_valid rises 3 edges after the last handshake.
- Corner product: cfg_len=1, pair (-128,-128) -> out_acc=16384; also (-128,127) -> -16256 and (127,127) -> 16129.
- Zero length: start with cfg_len=0 -> DONE next cycle with out_acc=0, no in_ready pulse. Start pulses held during DONE are ignored.
- Handshake stress: cfg_len=4, all pairs (1,1), in_valid toggled randomly and out_ready held low 5 cycles -> out_acc=4 held stable throughout, exactly 4 handshakes, and in_ready=0 after the 4th.
- Overflow: cfg_len=600, all pairs (-128,-128) -> out_acc=-6946816 (wrapped), out_ovf=1. A following job with cfg_len=1, pair (2,3) -> out_acc=6, out_ovf=0.
- Reset mid-job: rst pulsed after 2 of 5 handshakes -> next cycle busy=0, in_ready=0, out_valid=0. A new job with cfg_len=2, pairs (10,10), (1,1) -> out_acc=101 (no stale partial sum).
